// File: rtl/q_timing_queue.sv
// -----------------------------------------------------------------------------
// q_timing_queue
//
// Timing queue between the classical controller and the quantum operation
// unit. The controller emits quantum instructions and timing writes; each
// instruction is buffered together with the interval that was pending when it
// was pushed. The head entry is issued as a registered one-cycle pulse once
// its interval has elapsed since the previous issue.
//
// Optional feature (macro Q_TIMING_QUEUE_TIMESTAMP_EN):
//   Defined   : a free-running TIME_W cycle counter is sampled into o_issue_ts
//               on every pop edge.
//   Undefined : no counter, o_issue_ts is tied to 0 (port list unchanged).
//
// Ports:
//   clk             clock, all state changes on the rising edge
//   rst             synchronous, active-high reset
//   i_run           issue enable; 0 freezes countdown, arming and issue
//   i_q_inst_vld    push request for i_q_inst
//   i_q_inst        instruction to enqueue
//   i_q_time_write  timing write strobe
//   i_q_time_sel    0: replace pending interval, 1: saturating add
//   i_q_time_reg    timing value, bits [TIME_W-1:0] used
//   o_full          occupancy == DEPTH (post-edge)
//   o_empty         occupancy == 0 (post-edge)
//   o_count         current occupancy
//   o_issue_vld     one-cycle issue pulse
//   o_issue_inst    issued instruction, 0 when o_issue_vld is 0
//   o_overflow      sticky, set when a push is dropped
//   o_issue_ts      timestamp of the last issue (0 when timestamps disabled)
//
// Handshake: i_q_inst_vld is a push request with no ready return; a push is
// accepted when the queue is not full or when a pop happens in the same cycle.
// Otherwise it is dropped and o_overflow is set. The controller stalls on
// o_full. The issue side is a pure one-cycle valid pulse with no back-pressure.
//
// The FSM state is the internal signal `state` (IDLE / COUNT); "armed" is
// exactly state == COUNT.
// -----------------------------------------------------------------------------
module q_timing_queue #(
    parameter int DEPTH  = 16,
    parameter int INST_W = 64,
    parameter int TIME_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_run,
    input  logic                    i_q_inst_vld,
    input  logic [INST_W-1:0]       i_q_inst,
    input  logic                    i_q_time_write,
    input  logic                    i_q_time_sel,
    input  logic [63:0]             i_q_time_reg,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_issue_vld,
    output logic [INST_W-1:0]       o_issue_inst,
    output logic                    o_overflow,
    output logic [TIME_W-1:0]       o_issue_ts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = TIME_W + INST_W;

    localparam logic [PTR_W-1:0]  PTR_ONE   = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]  CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [TIME_W-1:0] TIME_ONE  = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    // Storage: each entry is {interval, instruction}.
    logic [ENT_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr_inc;
    logic [CNT_W-1:0]  count;

    // Pending interval and head countdown.
    logic [TIME_W-1:0] pend;
    logic [TIME_W-1:0] pend_eff;
    logic [TIME_W:0]   pend_sum;
    logic [TIME_W-1:0] time_val;
    logic [TIME_W-1:0] cnt;

    logic [TIME_W-1:0] head_ival;
    logic [INST_W-1:0] head_inst;
    logic [TIME_W-1:0] next_ival;

    // FSM decisions.
    logic pop;
    logic arm_head;
    logic arm_next;
    logic dec;

    logic push_acc;
    logic push_drop;

    // Upper bits of the timing register beyond TIME_W are intentionally ignored.
    logic unused_time_reg;
    assign unused_time_reg = ^i_q_time_reg;

    assign time_val   = i_q_time_reg[TIME_W-1:0];
    assign rd_ptr_inc = rd_ptr + PTR_ONE;
    assign head_ival  = mem[rd_ptr][ENT_W-1:INST_W];
    assign head_inst  = mem[rd_ptr][INST_W-1:0];
    assign next_ival  = mem[rd_ptr_inc][ENT_W-1:INST_W];

    // Countdown load value: intervals of 0 and 1 both mean "next cycle".
    function automatic logic [TIME_W-1:0] arm_val(input logic [TIME_W-1:0] ival);
        return (ival == '0) ? '0 : (ival - TIME_ONE);
    endfunction

    // Pending interval as seen by a same-cycle push: the time write lands first.
    assign pend_sum = {1'b0, pend} + {1'b0, time_val};

    always_comb begin
        pend_eff = pend;
        if (i_q_time_write) begin
            if (i_q_time_sel) begin
                pend_eff = pend_sum[TIME_W] ? '1 : pend_sum[TIME_W-1:0];
            end else begin
                pend_eff = time_val;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and decisions. All occupancy tests use the pre-edge
    // count, so an entry pushed this cycle is never armed on this edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        arm_head  = 1'b0;
        arm_next  = 1'b0;
        dec       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_run && (count != '0)) begin
                    arm_head  = 1'b1;
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (i_run) begin
                    if (cnt != '0) begin
                        dec = 1'b1;
                    end else begin
                        pop = 1'b1;
                        // A second resident entry takes over the countdown on
                        // the same edge so that issues stay exactly I apart.
                        if (count > CNT_ONE) begin
                            arm_next = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A pop frees a slot on the same edge, so a push while full still lands.
    assign push_acc  = i_q_inst_vld && ((count != CNT_DEPTH) || pop);
    assign push_drop = i_q_inst_vld && !push_acc;

    // ------------------------------------------------------------------
    // Datapath: pointers, occupancy, pending interval, countdown, issue.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pend         <= '0;
            cnt          <= '0;
            o_issue_vld  <= 1'b0;
            o_issue_inst <= '0;
            o_overflow   <= 1'b0;
        end else begin
            // An accepted push consumes the pending interval; otherwise any
            // time write simply updates it.
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                pend   <= '0;
            end else begin
                pend   <= pend_eff;
            end

            if (pop) begin
                rd_ptr <= rd_ptr_inc;
            end

            case ({push_acc, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            if (arm_head) begin
                cnt <= arm_val(head_ival);
            end else if (arm_next) begin
                cnt <= arm_val(next_ival);
            end else if (dec) begin
                cnt <= cnt - TIME_ONE;
            end

            o_issue_vld  <= pop;
            o_issue_inst <= pop ? head_inst : '0;

            if (push_drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Entry storage has no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= {pend_eff, i_q_inst};
        end
    end

    assign o_count = count;
    assign o_full  = (count == CNT_DEPTH);
    assign o_empty = (count == '0);

    // ------------------------------------------------------------------
    // Issue timestamp
    // ------------------------------------------------------------------
`ifdef Q_TIMING_QUEUE_TIMESTAMP_EN
    logic [TIME_W-1:0] ts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt     <= '0;
            o_issue_ts <= '0;
        end else begin
            ts_cnt <= ts_cnt + TIME_ONE;
            // The counter value present at the pop edge is what gets captured.
            if (pop) begin
                o_issue_ts <= ts_cnt;
            end
        end
    end
`else
    assign o_issue_ts = '0;
`endif

endmodule

// File: tb/tb_q_timing_queue.sv
// -----------------------------------------------------------------------------
// tb_q_timing_queue
//
// Self-checking bench for q_timing_queue. A behavioural model keeps the queue
// as a list of {interval, instruction} entries and schedules the head's pop
// in terms of "run edges" (edges with i_run=1): an entry armed on run edge r
// pops on run edge r + max(I,1). Every cycle the DUT outputs are compared to
// the model; directed scenarios add absolute-timing checks.
// -----------------------------------------------------------------------------
module tb_q_timing_queue;

  localparam int DEPTH  = 8;
  localparam int INST_W = 64;
  localparam int TIME_W = 32;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam longint unsigned TIME_MAX = (64'd1 << TIME_W) - 64'd1;

  // ---------------------------------------------------------------- clock/reset
  logic              clk = 1'b0;
  logic              rst;
  logic              i_run;
  logic              i_q_inst_vld;
  logic [INST_W-1:0] i_q_inst;
  logic              i_q_time_write;
  logic              i_q_time_sel;
  logic [63:0]       i_q_time_reg;
  logic              o_full;
  logic              o_empty;
  logic [CNT_W-1:0]  o_count;
  logic              o_issue_vld;
  logic [INST_W-1:0] o_issue_inst;
  logic              o_overflow;
  logic [TIME_W-1:0] o_issue_ts;

  always #5 clk = ~clk;

  q_timing_queue #(
    .DEPTH (DEPTH),
    .INST_W(INST_W),
    .TIME_W(TIME_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_run         (i_run),
    .i_q_inst_vld  (i_q_inst_vld),
    .i_q_inst      (i_q_inst),
    .i_q_time_write(i_q_time_write),
    .i_q_time_sel  (i_q_time_sel),
    .i_q_time_reg  (i_q_time_reg),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_count       (o_count),
    .o_issue_vld   (o_issue_vld),
    .o_issue_inst  (o_issue_inst),
    .o_overflow    (o_overflow),
    .o_issue_ts    (o_issue_ts)
  );

  // ---------------------------------------------------------------- model
  typedef struct {
    logic [TIME_W-1:0] ival;
    logic [INST_W-1:0] inst;
  } ent_t;

  ent_t              m_q[$];
  logic [TIME_W-1:0] m_pend;
  bit                m_armed;
  longint            m_runs;
  longint            m_due;
  logic              m_vld;
  logic [INST_W-1:0] m_inst;
  bit                m_ovf;
  logic [TIME_W-1:0] m_ts;
`ifdef Q_TIMING_QUEUE_TIMESTAMP_EN
  logic [TIME_W-1:0] m_tsctr;
`endif

  // ---------------------------------------------------------------- scoreboard
  int     n_checks;
  int     n_errors;
  longint cyc;
  longint iss_cyc[$];
  logic [INST_W-1:0] exp_q[$];   // instructions observed on the issue port

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint eff_ival(input logic [TIME_W-1:0] v);
    return (v == '0) ? 64'sd1 : longint'(v);
  endfunction

  task automatic model_step(input bit r, input bit run, input bit vld,
                            input logic [INST_W-1:0] inst, input bit tw,
                            input bit sel, input logic [63:0] tv);
    logic [TIME_W-1:0] eff;
    longint unsigned   s;
    bit                pop;
    if (r) begin
      m_q.delete();
      m_pend  = '0;
      m_armed = 0;
      m_runs  = 0;
      m_due   = 0;
      m_vld   = 1'b0;
      m_inst  = '0;
      m_ovf   = 0;
      m_ts    = '0;
`ifdef Q_TIMING_QUEUE_TIMESTAMP_EN
      m_tsctr = '0;
`endif
      return;
    end
    eff = m_pend;
    if (tw) begin
      if (sel) begin
        s   = longint'(m_pend) + longint'(tv[TIME_W-1:0]);
        eff = (s > TIME_MAX) ? TIME_MAX[TIME_W-1:0] : s[TIME_W-1:0];
      end else begin
        eff = tv[TIME_W-1:0];
      end
    end
    pop = 0;
    if (run) m_runs++;
    if (run && m_armed && (m_runs == m_due)) pop = 1;
    m_vld  = pop;
    m_inst = '0;
    if (pop) begin
      m_inst = m_q[0].inst;
      void'(m_q.pop_front());
`ifdef Q_TIMING_QUEUE_TIMESTAMP_EN
      m_ts = m_tsctr;
`endif
      if (m_q.size() > 0) m_due = m_runs + eff_ival(m_q[0].ival);
      else m_armed = 0;
    end else if (!m_armed && run && (m_q.size() > 0)) begin
      m_armed = 1;
      m_due   = m_runs + eff_ival(m_q[0].ival);
    end
`ifdef Q_TIMING_QUEUE_TIMESTAMP_EN
    m_tsctr = m_tsctr + 1'b1;
`endif
    if (vld && (m_q.size() < DEPTH)) begin
      m_q.push_back('{ival: eff, inst: inst});
      m_pend = '0;
    end else begin
      if (vld) m_ovf = 1;
      m_pend = eff;
    end
  endtask

  task automatic check_outputs();
    check("issue_vld",  {63'd0, o_issue_vld}, {63'd0, m_vld});
    check("issue_inst", o_issue_inst, m_inst);
    check("count",      64'(o_count), 64'(m_q.size()));
    check("full",       {63'd0, o_full},  {63'd0, (m_q.size() == DEPTH)});
    check("empty",      {63'd0, o_empty}, {63'd0, (m_q.size() == 0)});
    check("overflow",   {63'd0, o_overflow}, {63'd0, m_ovf});
    check("issue_ts",   64'(o_issue_ts), 64'(m_ts));
    if (o_issue_vld === 1'b1) begin
      iss_cyc.push_back(cyc);
      exp_q.push_back(o_issue_inst);
    end
  endtask

  // ---------------------------------------------------------------- driver
  task automatic step(input bit r, input bit run, input bit vld,
                      input logic [INST_W-1:0] inst, input bit tw,
                      input bit sel, input logic [63:0] tv);
    @(negedge clk);
    rst            = r;
    i_run          = run;
    i_q_inst_vld   = vld;
    i_q_inst       = inst;
    i_q_time_write = tw;
    i_q_time_sel   = sel;
    i_q_time_reg   = tv;
    model_step(r, run, vld, inst, tw, sel, tv);
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input bit run, input int n);
    for (int i = 0; i < n; i++) step(0, run, 0, '0, 0, 0, '0);
  endtask

  task automatic clear_log();
    iss_cyc.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    longint e0;
    n_checks       = 0;
    n_errors       = 0;
    cyc            = 0;
    rst            = 1'b1;
    i_run          = 1'b0;
    i_q_inst_vld   = 1'b0;
    i_q_inst       = '0;
    i_q_time_write = 1'b0;
    i_q_time_sel   = 1'b0;
    i_q_time_reg   = '0;

    // Reset state
    step(1, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, '0, 0, 0, '0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_empty", {63'd0, o_empty}, 64'd1);

    // Interval 5: issue in the cycle after E0+6
    clear_log();
    step(0, 1, 0, '0, 1, 0, 64'd5);
    step(0, 1, 1, 64'hA1, 0, 0, '0);
    e0 = cyc;
    idle(1, 12);
    check("t1_n_issues", 64'(iss_cyc.size()), 64'd1);
    if (iss_cyc.size() == 1) begin
      check("t1_issue_cycle", 64'(iss_cyc[0]), 64'(e0 + 6));
      check("t1_issue_inst",  exp_q[0], 64'hA1);
    end

    // Three zero-interval entries queued while frozen, then released
    clear_log();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 64'hB1 + 64'(i), 1, 0, 64'd0);
    idle(0, 3);
    check("t2_frozen_count", 64'(o_count), 64'd3);
    step(0, 1, 0, '0, 0, 0, '0);
    e0 = cyc;
    idle(1, 6);
    check("t2_n_issues", 64'(iss_cyc.size()), 64'd3);
    if (iss_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("t2_issue_cycle", 64'(iss_cyc[i]), 64'(e0 + 1 + i));
        check("t2_issue_inst",  exp_q[i], 64'hB1 + 64'(i));
      end
    end

    // Replace then add: 3 + 4 = 7, second entry I=0
    clear_log();
    step(0, 1, 0, '0, 1, 0, 64'd3);
    step(0, 1, 0, '0, 1, 1, 64'd4);
    step(0, 1, 1, 64'hC1, 0, 0, '0);
    e0 = cyc;
    step(0, 1, 1, 64'hC2, 0, 0, '0);
    idle(1, 12);
    check("t3_n_issues", 64'(iss_cyc.size()), 64'd2);
    if (iss_cyc.size() == 2) begin
      check("t3_first_cycle",  64'(iss_cyc[0]), 64'(e0 + 8));
      check("t3_second_cycle", 64'(iss_cyc[1]), 64'(e0 + 9));
      check("t3_order",        exp_q[1], 64'hC2);
    end

    // Fill to DEPTH, drop one, then drain
    clear_log();
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 64'hD0 + 64'(i), 0, 0, '0);
    check("t4_full",  {63'd0, o_full}, 64'd1);
    check("t4_count", 64'(o_count), 64'(DEPTH));
    check("t4_ovf_before", {63'd0, o_overflow}, 64'd0);
    step(0, 0, 1, 64'hDF, 0, 0, '0);
    check("t4_ovf_set", {63'd0, o_overflow}, 64'd1);
    idle(1, DEPTH + 6);
    check("t4_n_issues", 64'(iss_cyc.size()), 64'(DEPTH));
    check("t4_empty",    {63'd0, o_empty}, 64'd1);
    check("t4_ovf_sticky", {63'd0, o_overflow}, 64'd1);

    // Reset while counting with 4 entries queued
    clear_log();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 64'hE0 + 64'(i), 1, 0, 64'd3);
    check("t5_count_before", 64'(o_count), 64'd4);
    step(1, 1, 0, '0, 0, 0, '0);
    check("t5_rst_count", 64'(o_count), 64'd0);
    check("t5_rst_vld",   {63'd0, o_issue_vld}, 64'd0);
    check("t5_rst_ovf",   {63'd0, o_overflow}, 64'd0);
    clear_log();
    step(0, 1, 1, 64'hE9, 0, 0, '0);
    e0 = cyc;
    idle(1, 5);
    check("t5_n_issues", 64'(iss_cyc.size()), 64'd1);
    if (iss_cyc.size() == 1) check("t5_issue_cycle", 64'(iss_cyc[0]), 64'(e0 + 2));

    // Saturating add: near-max plus 5 must not wrap to a short interval
    clear_log();
    step(0, 0, 0, '0, 1, 0, 64'(TIME_MAX - 64'd2));
    step(0, 0, 1, 64'hF1, 1, 1, 64'd5);
    idle(1, 30);
    check("t6_no_issue", 64'(iss_cyc.size()), 64'd0);
    check("t6_count",    64'(o_count), 64'd1);
    step(1, 0, 0, '0, 0, 0, '0);

    // Randomized traffic, with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      bit                r;
      bit                run;
      bit                vld;
      bit                tw;
      bit                sel;
      logic [63:0]       tv;
      logic [INST_W-1:0] inst;
      r    = (i == 1500);
      run  = ($urandom_range(0, 9) != 0);
      vld  = ($urandom_range(0, 2) == 0);
      tw   = ($urandom_range(0, 3) == 0);
      sel  = $urandom_range(0, 1) == 1;
      tv   = {$urandom, 32'($urandom_range(0, 4))};
      inst = {$urandom, $urandom};
      step(r, run, vld, inst, tw, sel, tv);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/q_timing_queue.md
# q_timing_queue

Timing queue between the classical controller and the quantum operation unit. It captures quantum instructions and timing writes emitted by the controller and buffers them as {interval, instruction} entries in a FIFO. It issues each instruction as a single-cycle pulse once its programmed interval has elapsed since the previous issue. It also returns a full flag to the controller for stalling.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2
- INST_W, 64, quantum instruction width
- TIME_W, 32, interval and timestamp width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- i_run  in  1  issue enable; 0 freezes the countdown and issue
- i_q_inst_vld  in  1  push request for i_q_inst
- i_q_inst  in  INST_W  quantum instruction to enqueue
- i_q_time_write  in  1  timing write strobe
- i_q_time_sel  in  1  0: replace pending interval; 1: add to pending interval
- i_q_time_reg  in  64  timing value; bits [TIME_W-1:0] used
- o_full  out  1  count == DEPTH
- o_empty  out  1  count == 0
- o_count  out  $clog2(DEPTH)+1  current occupancy
- o_issue_vld  out  1  one-cycle issue pulse (registered)
- o_issue_inst  out  INST_W  issued instruction; 0 when o_issue_vld is 0
- o_overflow  out  1  sticky; set on a dropped push
- o_issue_ts  out  TIME_W  timestamp of the last issue (see Configuration)

## Operation
- Pending interval register P, TIME_W bits, reset value 0.
  - On a time write with sel=0: P ← value.
  - On a time write with sel=1: P ← P + value, saturating at all-ones.
- Push: each accepted push stores {P', inst}.
  - P' is P after any same-cycle time write has been applied, so the write takes effect first.
  - P resets to 0 in the same cycle.
- Interval I means consecutive o_issue_vld pulses are I cycles apart. I=0 is treated as 1.
- Head countdown cnt with flag armed. Arming loads cnt ← max(I,1)−1.
- State machine:
  - IDLE: queue empty or head not armed. If the head is valid and i_run=1, arm and go to COUNT.
  - COUNT: if i_run=1 and cnt≠0, decrement cnt. If i_run=1 and cnt==0, pop the head and register the issue.
    - If another entry already resides behind the head, arm it in the same edge and stay in COUNT.
    - Otherwise clear armed and go to IDLE.
- An entry pushed in the same cycle as a pop is never armed that edge; it arms on the next edge.
- i_run=0 freezes cnt, armed and issue. Pushes, time writes and o_count still update.
- Full: a push with count==DEPTH and no same-cycle pop is dropped, and o_overflow is set. A push while full with a same-cycle pop is accepted.
- Pop and push in the same cycle leave count unchanged. Read and write pointers wrap modulo DEPTH.

## Timing
- Reset values:
  - o_issue_vld=0, o_issue_inst=0, o_overflow=0, o_issue_ts=0
  - o_count=0, o_empty=1, o_full=0
  - P=0, armed=0, state IDLE
- Reset mid-operation flushes all entries and pending state. No issue pulse appears in the cycle after reset.
- Latency, empty queue, i_run=1, push at edge E0:
  - Entry arms at E1; pop at E1+I; o_issue_vld high in the cycle after E1+I.
  - With I≤1, o_issue_vld is high in the cycle after E2.
- Back-to-back entries with I≤1 already queued issue on consecutive cycles.
- o_full, o_empty and o_count reflect the post-edge occupancy. The controller must hold a push while o_full=1.

## Configuration
- Macro Q_TIMING_QUEUE_TIMESTAMP_EN.
  - Defined: a TIME_W free-running counter, reset to 0 and wrapping, increments every cycle. Its value at the pop edge is registered into o_issue_ts together with o_issue_vld. o_issue_ts holds until the next issue.
  - Undefined: no counter; o_issue_ts is tied to 0. The port list is unchanged.

## Test plan
- Time write sel=0 value 5, then push inst 0xA1 into an empty queue, i_run=1 → o_issue_inst=0xA1 for one cycle, in the cycle after edge E0+6. o_issue_inst=0 otherwise.
- Push three insts while i_run=0, each with time write 0, then raise i_run → three issue pulses on consecutive cycles, in FIFO order.
- Time write sel=0 value 3, then sel=1 value 4, then push two insts → first inst uses I=7; the second inst (no write) uses I=0→1. Issues are spaced 1 cycle apart.
- Push DEPTH+1 entries with i_run=0 → o_full=1 and o_count=DEPTH after DEPTH pushes. The extra push is dropped, o_overflow=1 and stays set. Then drain: DEPTH issues occur and o_empty=1.
- Assert rst while in COUNT with 4 entries queued → next cycle o_count=0, o_issue_vld=0, o_overflow=0. A subsequent push behaves as from reset.
- With Q_TIMING_QUEUE_TIMESTAMP_EN: issue at pop edge with counter=20 → o_issue_ts=20. Without the macro, o_issue_ts stays 0.
